regfile_sb: RTL and testbench
=============================

# regfile_sb

Integer register file with an attached write-pending scoreboard. It is the responder side of the decode-stage register-read interface: decode drives two read addresses and receives two 64-bit operands combinationally. The block also accepts the writeback-stage write port, bypasses same-cycle writes to the read ports, and tracks in-flight destination registers so decode can stall on read-after-write hazards.

## Interface

Parameters:
- NREG, 32: architectural registers, addressed by a 5-bit creg_addr_t; x0 is hardwired to zero.
- XLEN, 64: data width (u64).
- CNT_W, 2: width of each per-register pending counter; max in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock; only clock.
- resetn  in  1  asynchronous, active-low reset.
- ra1  in  5  read address, port 1 (from decode).
- ra2  in  5  read address, port 2 (from decode).
- rd1  out  XLEN  read data, port 1.
- rd2  out  XLEN  read data, port 2.
- busy1  out  1  operand at ra1 still pending; decode must stall.
- busy2  out  1  operand at ra2 still pending; decode must stall.
- wvalid  in  1  writeback write enable.
- wa  in  5  writeback destination.
- wd  in  XLEN  writeback data.
- issue_valid  in  1  an instruction with destination issue_rd leaves decode this cycle.
- issue_rd  in  5  destination of the issuing instruction.
- issue_ready  out  1  issue permitted; low when the pending counter of issue_rd is saturated.
- flush  in  1  squash all in-flight instructions younger than writeback.

## Operation

- Storage: regs[1..31], XLEN bits each; cnt[1..31], CNT_W bits each. x0 has neither.
- Read (combinational): rdN = 0 if raN==0; else wd if wvalid && wa==raN; else regs[raN].
- Write: on clk rise, if wvalid && wa!=0, regs[wa] <= wd. wvalid with wa==0 has no effect.
- Pending counters, per register r!=0, at clk rise:
  - inc = issue_valid && issue_ready && issue_rd==r && !flush.
  - dec = wvalid && wa==r && cnt[r]!=0.
  - flush: cnt[r] <= 0 for all r (overrides inc and dec).
  - inc && dec: unchanged. inc only: +1. dec only: -1.
  - wvalid to r with cnt[r]==0: write performed, counter stays 0 (no underflow).
- issue_ready = (issue_rd==0) || (cnt[issue_rd] != 2^CNT_W-1). issue_valid with issue_rd==0 never touches counters.
- busyN = raN!=0 && cnt[raN]!=0 && !(cnt[raN]==1 && wvalid && wa==raN). The last pending writer completing this cycle is covered by the bypass, so no stall.
- flush does not block a same-cycle write; wd still lands in regs.

## Timing

- Reset (resetn low, asynchronous): all regs 0, all cnt 0. Outputs settle to rd1=rd2=0 (unless bypass hits), busy1=busy2=0, issue_ready=1. Deassertion is sampled on the next clk rise.
- Read latency 0: rd, busy and issue_ready are purely combinational from current inputs and state.
- Write latency 1: a write at edge k is visible from regs (without bypass) from cycle k+1.
- Counter update latency 1: an issue at edge k raises busy for that register from cycle k+1.
- Reset asserted mid-operation clears state immediately. In-progress writes are lost.

## Test plan

- Reset: hold resetn=0 while writing wa=5, wd=0xDEAD -> after release, ra1=5 reads rd1=0, busy1=0, issue_ready=1.
- Write/read/bypass: write x3=0x1234 at edge 1 -> same cycle ra1=3 gives rd1=0x1234 via bypass, and the next cycle gives 0x1234 from storage. Write x0=0xFF -> rd of x0 stays 0.
- RAW stall: issue rd=7 -> next cycle ra2=7 gives busy2=1. In the writeback cycle (wvalid, wa=7, wd=0x55): busy2=0, rd2=0x55. The following cycle: cnt[7]=0, busy2=0.
- Saturation: issue rd=9 three times with CNT_W=2 -> issue_ready=0 while issue_rd=9, and a fourth issue_valid leaves cnt at 3. Then one writeback to x9 -> issue_ready=1 and cnt=2, with busy still 1.
- Simultaneous issue+writeback on x4 with cnt=1 -> cnt stays 1, regs[4] updated, and busy stays 1 next cycle.
- Flush: cnt[2]=2, cnt[6]=1, flush with issue_valid rd=2 and wvalid wa=6 wd=0x77 -> next cycle all cnt=0, busy low for all, regs[6]=0x77.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a write-pending scoreboard.
// Combinational reads with writeback bypass; per-register in-flight counters.
module regfile_sb #(
    parameter int NREG  = 32,
    parameter int XLEN  = 64,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            wvalid,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs [1:NREG-1];
    logic [CNT_W-1:0] cnt  [1:NREG-1];

    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt_iss;
    logic             hit1;
    logic             hit2;
    logic [NREG-1:1]  inc;
    logic [NREG-1:1]  dec;

    assign hit1 = wvalid && (wa == ra1);
    assign hit2 = wvalid && (wa == ra2);

    // Counter lookups; x0 has no counter and reads as idle.
    always_comb begin
        cnt1    = '0;
        cnt2    = '0;
        cnt_iss = '0;
        if (ra1 != 5'd0)      cnt1    = cnt[ra1];
        if (ra2 != 5'd0)      cnt2    = cnt[ra2];
        if (issue_rd != 5'd0) cnt_iss = cnt[issue_rd];
    end

    // Read port 1: x0 is zero, a same-cycle writeback wins over storage.
    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) begin
            if (hit1) rd1 = wd;
            else      rd1 = regs[ra1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0) begin
            if (hit2) rd2 = wd;
            else      rd2 = regs[ra2];
        end
    end

    // Stall unless nothing is pending or the last writer lands this cycle.
    always_comb begin
        busy1 = (ra1 != 5'd0) && (cnt1 != '0) && !((cnt1 == CNT_ONE) && hit1);
        busy2 = (ra2 != 5'd0) && (cnt2 != '0) && !((cnt2 == CNT_ONE) && hit2);
    end

    assign issue_ready = (issue_rd == 5'd0) || (cnt_iss != CNT_MAX);

    // Per-register increment/decrement requests for this edge.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc[r] = issue_valid && issue_ready && !flush
                     && (issue_rd == 5'(r));
            dec[r] = wvalid && (wa == 5'(r)) && (cnt[r] != '0);
        end
    end

    // Architectural storage; writes to x0 are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NREG; r++) regs[r] <= '0;
        end else if (wvalid && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Pending counters; flush squashes every in-flight writer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (flush)                 cnt[r] <= '0;
                else if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb
// against a plain array model of registers and pending counts.
module tb_regfile_sb;

    logic        clk;
    logic        resetn;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2;
    logic        busy1, busy2;
    logic        wvalid;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;

    int total = 0;
    int bad   = 0;

    logic [63:0] mreg [32];
    int          mcnt [32];

    regfile_sb dut (
        .clk(clk), .resetn(resetn),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .wvalid(wvalid), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .flush(flush)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_rd(input logic [4:0] a);
        if (a == 0) return 64'd0;
        if (wvalid && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        if (mcnt[a] == 1 && wvalid && wa == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_ready();
        return (issue_rd == 0) || (mcnt[issue_rd] < 3);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 64'd0;
            mcnt[i] = 0;
        end
    endtask

    task automatic m_commit();
        bit do_dec, do_inc;
        do_dec = wvalid && wa != 0 && mcnt[wa] > 0;
        do_inc = issue_valid && m_ready() && issue_rd != 0;
        if (wvalid && wa != 0) mreg[wa] = wd;
        if (flush) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
        end else begin
            if (do_dec) mcnt[wa] = mcnt[wa] - 1;
            if (do_inc) mcnt[issue_rd] = mcnt[issue_rd] + 1;
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".rd1"}, rd1, m_rd(ra1));
        chk({t, ".rd2"}, rd2, m_rd(ra2));
        chk({t, ".busy1"}, 64'(busy1), 64'(m_busy(ra1)));
        chk({t, ".busy2"}, 64'(busy2), 64'(m_busy(ra2)));
        chk({t, ".ready"}, 64'(issue_ready), 64'(m_ready()));
    endtask

    task automatic cyc(input string t);
        check_all(t);
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra1 = 0; ra2 = 0; wvalid = 0; wa = 0; wd = 0;
        issue_valid = 0; issue_rd = 0; flush = 0;
    endtask

    initial begin
        idle();
        m_reset();
        resetn = 0;
        wvalid = 1; wa = 5; wd = 64'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        idle();
        ra1 = 5; issue_rd = 5;
        #2;
        chk("rst.rd1", rd1, 64'd0);
        chk("rst.busy1", 64'(busy1), 64'd0);
        chk("rst.ready", 64'(issue_ready), 64'd1);
        cyc("rst");

        wvalid = 1; wa = 3; wd = 64'h1234; ra1 = 3;
        #2;
        chk("byp.rd1", rd1, 64'h1234);
        cyc("byp");
        idle(); ra1 = 3;
        #2;
        chk("stor.rd1", rd1, 64'h1234);
        cyc("stor");
        wvalid = 1; wa = 0; wd = 64'hFF; ra1 = 0;
        #2;
        chk("x0w.rd1", rd1, 64'd0);
        cyc("x0w");
        idle();
        #2;
        chk("x0r.rd1", rd1, 64'd0);
        cyc("x0r");

        issue_valid = 1; issue_rd = 7;
        #2;
        cyc("raw.iss");
        idle(); ra2 = 7;
        #2;
        chk("raw.busy2", 64'(busy2), 64'd1);
        cyc("raw.stall");
        wvalid = 1; wa = 7; wd = 64'h55; ra2 = 7;
        #2;
        chk("raw.wb.busy2", 64'(busy2), 64'd0);
        chk("raw.wb.rd2", rd2, 64'h55);
        cyc("raw.wb");
        idle(); ra2 = 7;
        #2;
        chk("raw.after.busy2", 64'(busy2), 64'd0);
        chk("raw.cnt7", 64'(dut.cnt[7]), 64'd0);
        cyc("raw.after");

        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = 9;
            #2;
            cyc("sat.iss");
        end
        issue_valid = 1; issue_rd = 9;
        #2;
        chk("sat.ready", 64'(issue_ready), 64'd0);
        cyc("sat.4th");
        idle();
        #2;
        chk("sat.cnt9", 64'(dut.cnt[9]), 64'd3);
        wvalid = 1; wa = 9; wd = 64'h99;
        cyc("sat.wb");
        idle(); issue_rd = 9; ra1 = 9;
        #2;
        chk("sat.ready2", 64'(issue_ready), 64'd1);
        chk("sat.cnt9b", 64'(dut.cnt[9]), 64'd2);
        chk("sat.busy1", 64'(busy1), 64'd1);
        cyc("sat.post");

        idle(); issue_valid = 1; issue_rd = 4;
        #2;
        cyc("sim.iss");
        issue_valid = 1; issue_rd = 4;
        wvalid = 1; wa = 4; wd = 64'hAB; ra1 = 4;
        #2;
        cyc("sim.both");
        idle(); ra1 = 4;
        #2;
        chk("sim.cnt4", 64'(dut.cnt[4]), 64'd1);
        chk("sim.rd1", rd1, 64'hAB);
        chk("sim.busy1", 64'(busy1), 64'd1);
        cyc("sim.post");

        idle(); flush = 1;
        #2;
        cyc("fl.clr");
        idle();
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1; issue_rd = 2;
            #2;
            cyc("fl.iss2");
        end
        issue_valid = 1; issue_rd = 6;
        #2;
        cyc("fl.iss6");
        flush = 1; issue_valid = 1; issue_rd = 2;
        wvalid = 1; wa = 6; wd = 64'h77;
        #2;
        cyc("fl.go");
        idle(); ra1 = 2; ra2 = 6;
        #2;
        for (int r = 1; r < 32; r++)
            chk($sformatf("fl.cnt%0d", r), 64'(dut.cnt[r]), 64'd0);
        chk("fl.busy1", 64'(busy1), 64'd0);
        chk("fl.busy2", 64'(busy2), 64'd0);
        chk("fl.rd6", rd2, 64'h77);
        cyc("fl.post");

        for (int n = 0; n < 400; n++) begin
            ra1 = 5'($urandom_range(0, 10));
            ra2 = 5'($urandom_range(0, 10));
            wvalid = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 10));
            wd = {$urandom, $urandom};
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 10));
            flush = ($urandom_range(0, 24) == 0);
            #2;
            cyc("rnd");
        end

        idle(); wvalid = 1; wa = 3; wd = 64'h3333;
        #2;
        cyc("mr.w");
        idle(); ra1 = 3; issue_rd = 9;
        resetn = 0;
        m_reset();
        #2;
        chk("mr.rd1", rd1, 64'd0);
        check_all("mr");
        @(posedge clk);
        #1;
        resetn = 1;
        #2;
        cyc("mr.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
